// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the FIFO read-side logic.
//   burst_state_t : burst reader FSM encoding (IDLE / BURST / DRAIN).
//   cnt_width()   : width of a FIFO occupancy count for a given depth.
//                   It is one bit wider than the address so "full" is representable.
// The beat record {data, last} depends on the data width.
// SystemVerilog-2012 packages cannot be parameterised, so each user declares
// that struct locally with its own DATA_WIDTH.
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } burst_state_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// stream_skid_buf
// Two-entry first-in first-out buffer with a valid/ready output stream.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_valid      : write strobe
//   i_data       : write data
//   o_valid      : head entry present (occupancy != 0)
//   o_data       : head entry
//   i_ready      : downstream accepts the head this cycle
//   o_occ        : current occupancy, 0..2
//
// There is no write-side ready. The writer must budget its writes against
// o_occ, for example by using credits. A write at occupancy 2 is legal only
// if the head is popped in the same cycle.
// Handshake: a beat transfers on a rising clock edge when o_valid && i_ready.
// While o_valid is high and i_ready is low, o_data holds steady.
module stream_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready,
  output logic [1:0]       o_occ
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       occ;
  logic             pop;

  assign o_valid = (occ != 2'd0);
  assign pop     = o_valid && i_ready;
  assign o_data  = mem[rd_ptr];
  assign o_occ   = occ;

  // At occupancy 2 with a simultaneous pop, wr_ptr equals rd_ptr.
  // The head is read combinationally before this edge overwrites it, so the
  // write is safe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (i_valid) begin
        mem[wr_ptr] <= i_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + {1'b0, i_valid} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
// Pops the synchronous FIFO and re-emits its words as a valid/ready stream.
// The stream is framed into bursts of BURST_LEN beats. The final beat of
// each burst carries o_last.
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_fifo_empty   : FIFO empty flag
//   i_fifo_count   : FIFO occupancy
//   i_fifo_data    : FIFO read data, valid one cycle after an accepted pop
//   o_fifo_rd_en   : FIFO pop request (never raised while empty)
//   i_flush        : level; lets a short burst start when count < BURST_LEN
//   o_valid/o_data/o_last/i_ready : output beat stream
//   o_busy         : FSM is not IDLE
//   o_burst_done   : wrapping count of completed bursts
//   o_state        : FSM state, for debug and checkers
// Stream handshake: a beat transfers on a rising edge with o_valid && i_ready.
// Once o_valid is high, o_data and o_last hold until the beat is accepted.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 64,
  parameter  int DEPTH      = 512,
  parameter  int BURST_LEN  = 16,
  localparam int CNT_W      = cnt_width(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_fifo_empty,
  input  logic [CNT_W-1:0]      i_fifo_count,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_rd_en,
  input  logic                  i_flush,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  input  logic                  i_ready,
  output logic                  o_busy,
  output logic [15:0]           o_burst_done,
  output burst_state_t          o_state
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } beat_t;

  localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);

  burst_state_t     state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             inflight_q;
  logic             inflight_last_q;
  logic [15:0]      done_q;
  logic             done_inc;
  logic             rd_en;

  beat_t            wr_beat;
  beat_t            head;
  logic             buf_valid;
  logic [1:0]       occ;
  logic             pop;
  logic [2:0]       credit;
  logic             credit_ok;

  // The buffer holds beats already stored plus the read still in flight.
  // A new pop is issued only if, after this cycle's drain, it still fits in
  // the 2-entry buffer. pop implies occ >= 1, so the subtraction cannot wrap.
  assign pop       = buf_valid && i_ready;
  assign credit    = {1'b0, occ} + {2'b0, inflight_q};
  assign credit_ok = (credit - {2'b0, pop}) <= 3'd1;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    rd_en    = 1'b0;
    done_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_fifo_count >= BURST_LEN_C) begin
          state_d = ST_BURST;
          rem_d   = BURST_LEN_C;
        end else if (i_flush && !i_fifo_empty && (i_fifo_count != '0)) begin
          // A short burst takes exactly the words stored right now.
          state_d = ST_BURST;
          rem_d   = i_fifo_count;
        end
      end
      ST_BURST: begin
        rd_en = (rem_q != '0) && !i_fifo_empty && credit_ok;
        if (rd_en) begin
          rem_d = rem_q - 1'b1;
        end
        if ((rem_q == '0) || (rd_en && (rem_q == CNT_W'(1)))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && head.last) begin
          state_d  = ST_IDLE;
          done_inc = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q         <= ST_IDLE;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= '0;
    end else begin
      state_q         <= state_d;
      rem_q           <= rem_d;
      inflight_q      <= rd_en;
      // Tag the word now: the final read of the burst becomes the last beat.
      inflight_last_q <= rd_en && (rem_q == CNT_W'(1));
      done_q          <= done_q + {15'd0, done_inc};
    end
  end

  assign wr_beat = '{data: i_fifo_data, last: inflight_last_q};

  stream_skid_buf #(
    .WIDTH($bits(beat_t))
  ) u_buf (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(inflight_q),
    .i_data (wr_beat),
    .o_valid(buf_valid),
    .o_data (head),
    .i_ready(i_ready),
    .o_occ  (occ)
  );

  assign o_fifo_rd_en = rd_en;
  assign o_valid      = buf_valid;
  assign o_data       = head.data;
  assign o_last       = buf_valid && head.last;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_burst_done = done_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader
// Drives fifo_burst_reader (BURST_LEN=16) and a BURST_LEN=1 copy.
// A behavioural FIFO stands in front of each instance. Accepted beats are
// scored against an expected {last, data} queue.
module tb_fifo_burst_reader;
  import fifo_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 64;
  localparam int BL    = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int EW    = DW + 1;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;
  logic rst = 1'b1;

  // ---------------- DUT 0 (BURST_LEN = 16) ----------------
  logic             f0_empty = 1'b1;
  logic [CNT_W-1:0] f0_count = '0;
  logic [DW-1:0]    f0_data  = '0;
  logic             rd_en0, valid0, last0, busy0;
  logic [DW-1:0]    data0;
  logic [15:0]      done0;
  burst_state_t     state0;
  logic             flush0 = 1'b0;
  logic             ready0 = 1'b1;

  fifo_burst_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .BURST_LEN(BL)) u_dut (
    .i_clk(i_clk), .i_rst(rst), .i_fifo_empty(f0_empty), .i_fifo_count(f0_count),
    .i_fifo_data(f0_data), .o_fifo_rd_en(rd_en0), .i_flush(flush0),
    .o_valid(valid0), .o_data(data0), .o_last(last0), .i_ready(ready0),
    .o_busy(busy0), .o_burst_done(done0), .o_state(state0)
  );

  // ---------------- DUT 1 (BURST_LEN = 1) ----------------
  logic             f1_empty = 1'b1;
  logic [CNT_W-1:0] f1_count = '0;
  logic [DW-1:0]    f1_data  = '0;
  logic             rd_en1, valid1, last1, busy1;
  logic [DW-1:0]    data1;
  logic [15:0]      done1;
  burst_state_t     state1;
  logic             flush1 = 1'b0;
  logic             ready1 = 1'b1;

  fifo_burst_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .BURST_LEN(1)) u_dut1 (
    .i_clk(i_clk), .i_rst(rst), .i_fifo_empty(f1_empty), .i_fifo_count(f1_count),
    .i_fifo_data(f1_data), .o_fifo_rd_en(rd_en1), .i_flush(flush1),
    .o_valid(valid1), .o_data(data1), .o_last(last1), .i_ready(ready1),
    .o_busy(busy1), .o_burst_done(done1), .o_state(state1)
  );

  // ---------------- behavioural FIFOs (1-cycle read latency) ----------------
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic          push0 = 1'b0, push1 = 1'b0;
  logic [DW-1:0] push_data0 = '0, push_data1 = '0;

  always @(posedge i_clk) begin
    if (rd_en0 && q0.size() != 0) f0_data <= q0.pop_front();
    if (push0) q0.push_back(push_data0);
    f0_count <= CNT_W'(q0.size());
    f0_empty <= (q0.size() == 0);
  end

  always @(posedge i_clk) begin
    if (rd_en1 && q1.size() != 0) f1_data <= q1.pop_front();
    if (push1) q1.push_back(push_data1);
    f1_count <= CNT_W'(q1.size());
    f1_empty <= (q1.size() == 0);
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp1_q[$];
  int total = 0;
  int bad   = 0;
  int pend0 = 0, plan_val0 = 0, next_val0 = 0;
  int out0 = 0;
  int viol_empty0 = 0, viol_occ0 = 0, viol_stable0 = 0, viol_empty1 = 0;
  bit hold0 = 1'b0;
  logic [DW-1:0] hold_data0 = '0;
  logic hold_last0 = 1'b0;
  int first_cyc = -1, last_cyc = -1;
  bit rnd_ready = 1'b0;

  task automatic chk(input string name, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic monitor0();
    logic [EW-1:0] e;
    if (rst) begin
      out0  = 0;
      hold0 = 1'b0;
      return;
    end
    if (rd_en0 && f0_empty) viol_empty0++;
    out0 = out0 + int'(rd_en0) - int'(valid0 && ready0);
    if (out0 > 2) viol_occ0++;
    if (hold0 && !(valid0 && data0 == hold_data0 && last0 == hold_last0)) viol_stable0++;
    hold0      = valid0 && !ready0;
    hold_data0 = data0;
    hold_last0 = last0;
    if (valid0 && ready0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL beat0 unexpected beat got=%h, none expected", {last0, data0});
      end else begin
        e = exp_q.pop_front();
        if ({last0, data0} != e) begin
          bad++;
          $display("FAIL beat0 got last/data=%h exp=%h", {last0, data0}, e);
        end
      end
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
    end
  endtask

  task automatic monitor1();
    logic [EW-1:0] e;
    if (rst) return;
    if (rd_en1 && f1_empty) viol_empty1++;
    if (valid1 && ready1) begin
      total++;
      if (exp1_q.size() == 0) begin
        bad++;
        $display("FAIL beat1 unexpected beat got=%h, none expected", {last1, data1});
      end else begin
        e = exp1_q.pop_front();
        if ({last1, data1} != e) begin
          bad++;
          $display("FAIL beat1 got last/data=%h exp=%h", {last1, data1}, e);
        end
      end
    end
  endtask

  // One clock: sample at the falling edge, then move to just after the rising edge.
  task automatic step();
    @(negedge i_clk);
    monitor0();
    monitor1();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_ready();
    ready0 = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // Expected framing: full bursts while enough words are pending. On flush,
  // the remainder goes out as one short burst.
  task automatic plan0(input bit fl);
    int n;
    while (pend0 >= BL) begin
      for (int k = 0; k < BL; k++) begin
        exp_q.push_back({1'(k == BL - 1), DW'(plan_val0)});
        plan_val0++;
      end
      pend0 -= BL;
    end
    if (fl && pend0 > 0) begin
      n = pend0;
      for (int k = 0; k < n; k++) begin
        exp_q.push_back({1'(k == n - 1), DW'(plan_val0)});
        plan_val0++;
      end
      pend0 = 0;
    end
  endtask

  task automatic push_words0(input int n);
    for (int i = 0; i < n; i++) begin
      push0      = 1'b1;
      push_data0 = DW'(next_val0);
      next_val0++;
      drive_ready();
      step();
    end
    push0 = 1'b0;
  endtask

  task automatic run_until_idle0(input int budget);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !busy0 && !valid0) && n < budget) begin
      drive_ready();
      step();
      n++;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $display("FAIL idle_timeout0 waited=%0d cycles, required drain within budget", n);
    end
    ready0 = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int n_words;
    bit flush;
    bit rnd;
    int exp_done;
    int exp_count;
    int exp_span;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int s, v, seen, n;

    vecs[0] = '{n_words: 16, flush: 1'b0, rnd: 1'b0, exp_done: 1, exp_count: 0, exp_span: 15};
    vecs[1] = '{n_words: 40, flush: 1'b0, rnd: 1'b0, exp_done: 3, exp_count: 8, exp_span: -1};
    vecs[2] = '{n_words: 0,  flush: 1'b1, rnd: 1'b0, exp_done: 4, exp_count: 0, exp_span: 7};
    vecs[3] = '{n_words: 16, flush: 1'b0, rnd: 1'b1, exp_done: 5, exp_count: 0, exp_span: -1};
    vecs[4] = '{n_words: 20, flush: 1'b1, rnd: 1'b1, exp_done: 7, exp_count: 0, exp_span: -1};

    // Reset state
    step();
    step();
    chk("rst_valid", valid0, 0);
    chk("rst_rd_en", rd_en0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_last", last0, 0);
    chk("rst_data", data0, 0);
    chk("rst_done", done0, 0);
    chk("rst_state", longint'(state0), longint'(ST_IDLE));
    rst = 1'b0;
    step();

    // Table-driven bursts
    for (int i = 0; i < 5; i++) begin
      pend0 += vecs[i].n_words;
      plan0(vecs[i].flush);
      first_cyc = -1;
      last_cyc  = -1;
      rnd_ready = vecs[i].rnd;
      push_words0(vecs[i].n_words);
      flush0 = vecs[i].flush;
      run_until_idle0(2000);
      flush0 = 1'b0;
      rnd_ready = 1'b0;
      chk($sformatf("vec%0d_done", i), done0, vecs[i].exp_done);
      chk($sformatf("vec%0d_count", i), f0_count, vecs[i].exp_count);
      if (vecs[i].exp_span >= 0)
        chk($sformatf("vec%0d_span", i), last_cyc - first_cyc, vecs[i].exp_span);
    end

    // Under threshold, no flush: no pops. Reaching 16 then starts a burst.
    s = next_val0;
    pend0 += 5;
    plan0(1'b0);
    push_words0(5);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      drive_ready();
      step();
      if (rd_en0) seen++;
    end
    chk("under_thr_rd_en", seen, 0);
    chk("under_thr_busy", busy0, 0);
    pend0 += 11;
    plan0(1'b0);
    push_words0(11);
    chk("thr_prev_idle", busy0, 0);
    step();
    chk("thr_rd_en", rd_en0, 1);
    chk("lat_valid_c1", valid0, 0);
    step();
    chk("lat_valid_c2", valid0, 0);
    step();
    chk("lat_valid_c3", valid0, 1);
    chk("lat_data_c3", data0, s);
    run_until_idle0(500);
    chk("thr_done", done0, 8);

    // Reset while beat 7 of a burst is presented
    v = next_val0;
    pend0 += 16;
    plan0(1'b0);
    push_words0(16);
    n = 0;
    while (!(valid0 && data0 == DW'(v + 7)) && n < 100) begin
      drive_ready();
      step();
      n++;
    end
    chk("mid_reach_beat7", n < 100, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", valid0, 0);
    chk("mid_rst_rd_en", rd_en0, 0);
    chk("mid_rst_last", last0, 0);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_data", data0, 0);
    chk("mid_rst_done", done0, 0);
    chk("mid_fifo_left", q0.size(), 7);
    exp_q.delete();
    step();
    rst = 1'b0;
    step();
    chk("post_rst_state", longint'(state0), longint'(ST_IDLE));
    chk("post_rst_valid", valid0, 0);
    pend0     = 7;
    plan_val0 = v + 9;
    flush0    = 1'b1;
    plan0(1'b1);
    run_until_idle0(500);
    flush0 = 1'b0;
    chk("post_rst_done", done0, 1);
    chk("post_rst_count", f0_count, 0);

    // BURST_LEN = 1: three single-beat bursts
    flush1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp1_q.push_back({1'b1, DW'(100 + i)});
      push1      = 1'b1;
      push_data1 = DW'(100 + i);
      step();
    end
    push1 = 1'b0;
    n = 0;
    while (!(exp1_q.size() == 0 && !busy1 && !valid1) && n < 200) begin
      step();
      n++;
    end
    chk("bl1_drained", n < 200, 1);
    flush1 = 1'b0;
    chk("bl1_done", done1, 3);
    chk("bl1_count", f1_count, 0);

    // Whole-run invariants
    chk("rd_en_while_empty0", viol_empty0, 0);
    chk("rd_en_while_empty1", viol_empty1, 0);
    chk("outstanding_over_2", viol_occ0, 0);
    chk("data_unstable", viol_stable0, 0);
    chk("exp_left0", exp_q.size(), 0);
    chk("exp_left1", exp1_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side engine for the team's synchronous FIFO. It pops the FIFO through its rd_en/empty/count interface and re-emits the data as a valid/ready stream, framed into bursts of BURST_LEN beats with a last marker.
- A burst starts only once enough data is stored, or on an explicit flush for a partial burst.
- A 2-entry output buffer absorbs the FIFO's 1-cycle read latency, giving 1 beat/cycle throughput under back-pressure.

Parameters:
- DATA_WIDTH, 64, width of FIFO data and stream data.
- DEPTH, 512, depth of the attached FIFO. Sets CNT_W = $clog2(DEPTH)+1 (localparam).
- BURST_LEN, 16, beats per full burst. Range 1..DEPTH.

Ports:
- i_clk  in  1  single clock for all logic.
- i_rst  in  1  asynchronous reset, active-high.
- i_fifo_empty  in  1  FIFO empty flag.
- i_fifo_count  in  CNT_W  FIFO occupancy.
- i_fifo_data  in  DATA_WIDTH  FIFO read data, valid the cycle after an accepted rd_en.
- o_fifo_rd_en  out  1  FIFO pop request.
- i_flush  in  1  level; allows a partial burst when count < BURST_LEN.
- o_valid  out  1  stream beat valid.
- o_data  out  DATA_WIDTH  stream beat data.
- o_last  out  1  final beat of the current burst.
- i_ready  in  1  downstream accept.
- o_busy  out  1  high while not in IDLE.
- o_burst_done  out  16  wrapping count of completed bursts.

Behaviour:
- Reset (async, i_rst=1):
  - State goes to IDLE.
  - Buffer occupancy, in-flight flag, remaining counter and o_burst_done are cleared.
  - o_fifo_rd_en, o_valid, o_last and o_busy go to 0; o_data goes to 0.
  - Reset mid-burst discards buffered beats; the FIFO keeps whatever it has not popped.
- Read timing:
  - A pop is accepted when o_fifo_rd_en=1. o_fifo_rd_en is never asserted while i_fifo_empty=1.
  - The data is captured from i_fifo_data exactly 1 cycle later (in-flight flag) into the 2-entry buffer, tagged with last = (this was the final read of the burst).
- Credit rule: o_fifo_rd_en = (state==BURST) && remaining!=0 && !i_fifo_empty && (occ + inflight - pop <= 1), where pop = o_valid && i_ready. The buffer therefore never overflows.
- Stream side:
  - o_valid = occ != 0. o_data and o_last come from the head entry.
  - Once o_valid rises, o_data and o_last hold until accepted.
- IDLE:
  - If i_fifo_count >= BURST_LEN: go to BURST with remaining = BURST_LEN.
  - Else if i_flush && !i_fifo_empty: go to BURST with remaining = i_fifo_count, which is < BURST_LEN.
  - Else stay in IDLE.
- BURST:
  - Each accepted pop decrements remaining.
  - When remaining reaches 0, go to DRAIN.
  - The flush level is ignored once a burst is started.
- DRAIN:
  - Stay until the beat with o_last=1 is accepted.
  - Then increment o_burst_done (mod 2^16) and return to IDLE. The next burst can start on the following cycle.
- Throughput and latency:
  - With i_ready=1 and enough data: 1 beat/cycle.
  - First o_valid appears 2 cycles after leaving IDLE: 1 cycle for rd_en, 1 cycle for capture.
- Boundary cases:
  - If the FIFO goes empty mid-burst (not possible for a count-qualified burst, but tolerated), reads stall until !i_fifo_empty.
  - Simultaneous buffer write and pop is legal at occ=2.
  - BURST_LEN=1: every beat has o_last=1.

Decomposition:
- Shared package fifo_pkg holds:
  - the state encoding (IDLE, BURST, DRAIN);
  - the CNT_W function/constant;
  - a beat struct {data, last}.
- Natural sub-module: stream_skid_buf, a 2-entry valid/ready buffer with an occupancy output, reused for other stream outputs.

Test Plan:
- Preload 16 words 0..15, hold i_ready=1. Required: one burst on consecutive cycles, o_data 0..15, o_last only on value 15, o_burst_done=1, FIFO count ends at 0.
- Preload 40 words, i_ready=1. Required: two bursts of 16, then the FSM idles with count=8; asserting i_flush then gives a burst of 8 with o_last on word 39, and o_burst_done=3.
- Full burst with i_ready toggling 1,0,0,1 randomly. Required: no dropped or duplicated beats, o_data stable while o_valid && !i_ready, and o_fifo_rd_en never raises occ above 2.
- 5 words, no flush. Required: o_fifo_rd_en stays 0 for 100 cycles. Then the FIFO reaches 16 and the burst starts with rd_en on the next cycle.
- Assert i_rst in the middle of beat 7 of a burst. Required: all outputs go to 0 immediately, state is IDLE after release, and the remaining FIFO contents drive the next burst correctly.
- BURST_LEN=1 build, 3 words plus flush. Required: 3 single-beat bursts, each beat with o_last=1, o_burst_done=3.
